// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC / control-flow stage: branch funct3 codes,
// interrupt FSM state type, default reset and ISR addresses, branch decode.
package pc_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_ISR_BASE = 32'h0000_1000;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_ISR = 1'b1
  } state_e;

  // Branch condition from the comparator flags; 010/011 are never taken.
  function automatic logic branch_cond(logic [2:0] f3, logic less, logic equal);
    logic c;
    case (f3)
      F3_BEQ:           c = equal;
      F3_BNE:           c = ~equal;
      F3_BLT, F3_BLTU:  c = less;
      F3_BGE, F3_BGEU:  c = ~less;
      default:          c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Control/flow bus between the decode side and pc_ctrl.
// master: decode/test side driving the i_* signals; slave: pc_ctrl.
interface pc_ctrl_if;
  logic        i_stall;
  logic        i_is_branch;
  logic [2:0]  i_funct3;
  logic        i_br_less;
  logic        i_br_equal;
  logic        o_br_un;
  logic        i_is_jal;
  logic        i_is_jalr;
  logic [31:0] i_alu_target;
  logic        i_is_mret;
  logic        i_irq;
  logic        i_irq_en;
  logic [31:0] o_pc;
  logic        o_taken;
  logic        o_flush;
  logic        o_irq_ack;
  logic        o_in_isr;
  logic [31:0] o_mepc;

  modport slave (
    input  i_stall, i_is_branch, i_funct3, i_br_less, i_br_equal, i_is_jal, i_is_jalr,
           i_alu_target, i_is_mret, i_irq, i_irq_en,
    output o_br_un, o_pc, o_taken, o_flush, o_irq_ack, o_in_isr, o_mepc
  );

  modport master (
    output i_stall, i_is_branch, i_funct3, i_br_less, i_br_equal, i_is_jal, i_is_jalr,
           i_alu_target, i_is_mret, i_irq, i_irq_en,
    input  o_br_un, o_pc, o_taken, o_flush, o_irq_ack, o_in_isr, o_mepc
  );
endinterface

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the external interrupt request.
// Macro IRQ_SYNC_EN: when defined, i_irq first passes through a two-flop
// synchroniser (adds two cycles of latency); otherwise it is sampled directly.
module irq_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  output logic o_edge
);

`ifdef IRQ_SYNC_EN
  logic sync1, sync2, prev;

  // Two-flop synchroniser followed by the edge-detect history flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= i_irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // One-cycle pulse on a 0->1 transition of the synchronised request.
  always_comb o_edge = sync2 & ~prev;
`else
  logic prev;

  // History flop sampling the raw request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) prev <= 1'b0;
    else       prev <= i_irq;
  end

  // One-cycle pulse on a 0->1 transition of the raw request.
  always_comb o_edge = i_irq & ~prev;
`endif

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and control-flow stage: next-PC selection (sequential,
// branch, JAL/JALR, interrupt entry, MRET), interrupt pending latch, mepc and
// a two-state interrupt FSM. Optional macro IRQ_SYNC_EN enables the irq
// synchroniser inside irq_edge_sync.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] ISR_BASE = DEF_ISR_BASE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  pc_ctrl_if.slave   bus
);

  state_e      state;
  logic        pending;
  logic [31:0] pc;
  logic [31:0] mepc;
  logic        irq_edge;

  logic        taken;
  logic        entry;
  logic        mret_ret;
  logic [31:0] target;
  logic [31:0] next_pc;

  irq_edge_sync u_irq_edge_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_irq  (bus.i_irq),
    .o_edge (irq_edge)
  );

  // Combinational control decode and next-PC selection.
  always_comb begin
    taken    = (bus.i_is_branch & branch_cond(bus.i_funct3, bus.i_br_less, bus.i_br_equal))
               | bus.i_is_jal | bus.i_is_jalr;
    target   = bus.i_is_jalr ? {bus.i_alu_target[31:1], 1'b0} : bus.i_alu_target;
    // Normal next PC; also what mepc saves on entry so a redirect is not lost.
    next_pc  = taken ? target : pc + 32'd4;
    entry    = (state == S_RUN) & pending & bus.i_irq_en & ~bus.i_stall;
    mret_ret = (state == S_ISR) & bus.i_is_mret & ~bus.i_stall;

    bus.o_br_un   = (bus.i_funct3 == F3_BLT) | (bus.i_funct3 == F3_BGE);
    bus.o_taken   = taken;
    bus.o_flush   = taken | entry | mret_ret;
    bus.o_irq_ack = entry;
    bus.o_in_isr  = (state == S_ISR);
    bus.o_pc      = pc;
    bus.o_mepc    = mepc;
  end

  // PC, mepc, pending latch and interrupt FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_RUN;
      pending <= 1'b0;
      pc      <= RESET_PC;
      mepc    <= 32'h0;
    end else begin
      // Edge capture keeps running through stalls; a fresh edge beats the clear.
      pending <= irq_edge | (pending & ~entry);
      if (!bus.i_stall) begin
        if (entry) begin
          state <= S_ISR;
          pc    <= ISR_BASE;
          mepc  <= next_pc;
        end else if (mret_ret) begin
          state <= S_RUN;
          pc    <= mepc;
        end else begin
          pc    <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_ctrl_if bus ();

  pc_ctrl #(
    .RESET_PC (32'h0000_0000),
    .ISR_BASE (32'h0000_1000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.i_stall      = 1'b0;
    bus.i_is_branch  = 1'b0;
    bus.i_funct3     = 3'b000;
    bus.i_br_less    = 1'b0;
    bus.i_br_equal   = 1'b0;
    bus.i_is_jal     = 1'b0;
    bus.i_is_jalr    = 1'b0;
    bus.i_alu_target = 32'h0;
    bus.i_is_mret    = 1'b0;
  endtask

  // Ticks until o_irq_ack is seen; lat=0 means it never came.
  task automatic wait_ack(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.o_irq_ack === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_ctrl();
    bus.i_irq = 1'b0;
    bus.i_irq_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus.o_pc, 32'h0); end
    checks++; if (bus.o_mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc got %h want %h", bus.o_mepc, 32'h0); end
    checks++; if (bus.o_in_isr !== 1'b0 || bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL reset_isr got %b/%b want 0/0", bus.o_in_isr, bus.o_irq_ack); end
    checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.o_flush); end
    tick();
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got %h want %h", bus.o_pc, 32'h4); end
    tick();
    checks++; if (bus.o_pc !== 32'h8) begin errors++; $display("FAIL seq_pc8 got %h want %h", bus.o_pc, 32'h8); end
  endtask

  task automatic test_branch();
    // BLT, less=1 -> taken to 0x40
    bus.i_is_branch = 1'b1; bus.i_funct3 = 3'b100; bus.i_br_less = 1'b1;
    bus.i_alu_target = 32'h40;
    #1;
    checks++; if (bus.o_br_un !== 1'b1) begin errors++; $display("FAIL blt_br_un got %b want 1", bus.o_br_un); end
    checks++; if (bus.o_taken !== 1'b1 || bus.o_flush !== 1'b1) begin errors++; $display("FAIL blt_taken got %b/%b want 1/1", bus.o_taken, bus.o_flush); end
    tick();
    checks++; if (bus.o_pc !== 32'h40) begin errors++; $display("FAIL blt_pc got %h want %h", bus.o_pc, 32'h40); end
    // BGEU, less=1 -> not taken
    bus.i_funct3 = 3'b111;
    #1;
    checks++; if (bus.o_br_un !== 1'b0) begin errors++; $display("FAIL bgeu_br_un got %b want 0", bus.o_br_un); end
    checks++; if (bus.o_taken !== 1'b0 || bus.o_flush !== 1'b0) begin errors++; $display("FAIL bgeu_taken got %b/%b want 0/0", bus.o_taken, bus.o_flush); end
    tick();
    checks++; if (bus.o_pc !== 32'h44) begin errors++; $display("FAIL bgeu_pc got %h want %h", bus.o_pc, 32'h44); end
    // BNE with equal=0 -> taken to 0x200
    bus.i_funct3 = 3'b001; bus.i_br_equal = 1'b0; bus.i_alu_target = 32'h200;
    tick();
    checks++; if (bus.o_pc !== 32'h200) begin errors++; $display("FAIL bne_pc got %h want %h", bus.o_pc, 32'h200); end
    // funct3 010 never taken even with both flags set
    bus.i_funct3 = 3'b010; bus.i_br_equal = 1'b1; bus.i_br_less = 1'b1;
    #1;
    checks++; if (bus.o_taken !== 1'b0) begin errors++; $display("FAIL f3_010_taken got %b want 0", bus.o_taken); end
    tick();
    checks++; if (bus.o_pc !== 32'h204) begin errors++; $display("FAIL f3_010_pc got %h want %h", bus.o_pc, 32'h204); end
    clear_ctrl();
  endtask

  task automatic test_jump();
    bus.i_is_jalr = 1'b1; bus.i_alu_target = 32'h103;
    #1;
    checks++; if (bus.o_flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got %b want 1", bus.o_flush); end
    tick();
    checks++; if (bus.o_pc !== 32'h102) begin errors++; $display("FAIL jalr_pc got %h want %h", bus.o_pc, 32'h102); end
    clear_ctrl();
    bus.i_is_jal = 1'b1; bus.i_alu_target = 32'hFFFF_FFFC;
    tick();
    clear_ctrl();
    checks++; if (bus.o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_pc got %h want %h", bus.o_pc, 32'hFFFF_FFFC); end
    tick();
    checks++; if (bus.o_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", bus.o_pc, 32'h0); end
    // MRET outside the ISR behaves as a plain sequential instruction
    bus.i_is_mret = 1'b1;
    #1;
    checks++; if (bus.o_flush !== 1'b0) begin errors++; $display("FAIL mret_nop_flush got %b want 0", bus.o_flush); end
    tick();
    clear_ctrl();
    checks++; if (bus.o_pc !== 32'h4) begin errors++; $display("FAIL mret_nop_pc got %h want %h", bus.o_pc, 32'h4); end
  endtask

  task automatic test_irq_entry();
    int lat;
    bus.i_irq_en = 1'b1;
    bus.i_irq = 1'b1;
    wait_ack(lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL irq_latency got %0d want %0d", lat, EXP_LAT); end
    // Taken BEQ in the entry cycle: its target must land in mepc
    bus.i_is_branch = 1'b1; bus.i_funct3 = 3'b000; bus.i_br_equal = 1'b1;
    bus.i_alu_target = 32'h80;
    #1;
    checks++; if (bus.o_irq_ack !== 1'b1 || bus.o_flush !== 1'b1) begin errors++; $display("FAIL entry_ack got %b/%b want 1/1", bus.o_irq_ack, bus.o_flush); end
    tick();
    clear_ctrl();
    #1;
    checks++; if (bus.o_pc !== 32'h1000) begin errors++; $display("FAIL entry_pc got %h want %h", bus.o_pc, 32'h1000); end
    checks++; if (bus.o_mepc !== 32'h80) begin errors++; $display("FAIL entry_mepc got %h want %h", bus.o_mepc, 32'h80); end
    checks++; if (bus.o_in_isr !== 1'b1 || bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL entry_state got %b/%b want 1/0", bus.o_in_isr, bus.o_irq_ack); end
    bus.i_is_mret = 1'b1;
    #1;
    checks++; if (bus.o_flush !== 1'b1) begin errors++; $display("FAIL mret_flush got %b want 1", bus.o_flush); end
    tick();
    clear_ctrl();
    #1;
    checks++; if (bus.o_pc !== 32'h80) begin errors++; $display("FAIL mret_pc got %h want %h", bus.o_pc, 32'h80); end
    checks++; if (bus.o_in_isr !== 1'b0) begin errors++; $display("FAIL mret_in_isr got %b want 0", bus.o_in_isr); end
    // Level held high: no new edge, so no re-entry
    checks++; if (bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL level_no_reentry got %b want 0", bus.o_irq_ack); end
  endtask

  task automatic test_nested_and_stall();
    int lat;
    bus.i_irq = 1'b0;
    tick();
    bus.i_irq = 1'b1;
    wait_ack(lat);
    checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL irq2_latency got %0d want %0d", lat, EXP_LAT); end
    bus.i_is_jal = 1'b1; bus.i_alu_target = 32'h300;
    tick();
    clear_ctrl();
    #1;
    checks++; if (bus.o_mepc !== 32'h300) begin errors++; $display("FAIL irq2_mepc got %h want %h", bus.o_mepc, 32'h300); end
    // New edge inside the ISR: pending but not taken
    bus.i_irq = 1'b0;
    tick();
    bus.i_irq = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL nest_ack got %b want 0", bus.o_irq_ack); end
    end
    checks++; if (bus.o_pc !== 32'h1018 || bus.o_in_isr !== 1'b1) begin errors++; $display("FAIL nest_pc got %h/%b want %h/1", bus.o_pc, bus.o_in_isr, 32'h1018); end
    bus.i_is_mret = 1'b1;
    tick();
    clear_ctrl();
    bus.i_stall = 1'b1;
    #1;
    checks++; if (bus.o_pc !== 32'h300) begin errors++; $display("FAIL ret_pc got %h want %h", bus.o_pc, 32'h300); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.o_pc !== 32'h300 || bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL stall_hold got %h/%b want %h/0", bus.o_pc, bus.o_irq_ack, 32'h300); end
    end
    bus.i_stall = 1'b0;
    #1;
    checks++; if (bus.o_irq_ack !== 1'b1) begin errors++; $display("FAIL pending_survives got %b want 1", bus.o_irq_ack); end
    tick();
    checks++; if (bus.o_pc !== 32'h1000 || bus.o_mepc !== 32'h304) begin errors++; $display("FAIL reentry got %h/%h want %h/%h", bus.o_pc, bus.o_mepc, 32'h1000, 32'h304); end
  endtask

  task automatic test_reset_in_isr();
    // Arm a pending edge inside the ISR, then reset must drop it
    bus.i_irq = 1'b0;
    tick();
    bus.i_irq = 1'b1;
    repeat (4) tick();
    bus.i_irq = 1'b0;
    checks++; if (bus.o_in_isr !== 1'b1) begin errors++; $display("FAIL pre_reset_isr got %b want 1", bus.o_in_isr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.o_pc !== 32'h0 || bus.o_in_isr !== 1'b0 || bus.o_mepc !== 32'h0) begin errors++; $display("FAIL isr_reset got %h/%b/%h want 0/0/0", bus.o_pc, bus.o_in_isr, bus.o_mepc); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.o_irq_ack !== 1'b0) begin errors++; $display("FAIL pending_dropped got %b want 0", bus.o_irq_ack); end
    end
    checks++; if (bus.o_pc !== 32'h10) begin errors++; $display("FAIL post_reset_pc got %h want %h", bus.o_pc, 32'h10); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_irq_entry();
    test_nested_and_stall();
    test_reset_in_isr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and control-flow stage for the single-cycle RISC core, sitting directly downstream of the branch comparator (brc). It consumes the comparator's less/equal flags and decides the next PC: sequential, taken branch, JAL/JALR, external-interrupt entry, or MRET return. It also drives the comparator's signed/unsigned select. It owns the PC register, the interrupt pending latch, the saved return address (mepc) and a two-state interrupt FSM.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ISR_BASE, 32'h0000_1000, interrupt service routine entry address

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- i_stall  in  1  hold PC and FSM this cycle
- i_is_branch  in  1  current instruction is a B-type
- i_funct3  in  3  branch funct3
- i_br_less  in  1  from brc
- i_br_equal  in  1  from brc
- o_br_un  out  1  to brc: high for funct3 100/101 (signed compare), low otherwise
- i_is_jal  in  1  JAL
- i_is_jalr  in  1  JALR
- i_alu_target  in  32  computed target (pc+imm or rs1+imm)
- i_is_mret  in  1  MRET
- i_irq  in  1  external interrupt request, level
- i_irq_en  in  1  global interrupt enable
- o_pc  out  32  current PC, registered
- o_taken  out  1  branch or jump taken this cycle
- o_flush  out  1  next PC is not o_pc+4
- o_irq_ack  out  1  one-cycle pulse on interrupt entry
- o_in_isr  out  1  FSM in S_ISR
- o_mepc  out  32  saved return address

## Operation
- Branch decision uses i_funct3: 000 taken on equal; 001 on not equal; 100/110 on less; 101/111 on not less; 010/011 never taken.
- o_taken = (i_is_branch & cond) | i_is_jal | i_is_jalr.
- Redirect target is i_alu_target, with bit 0 cleared for JALR. Otherwise the next PC is o_pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Pending latch sets on a rising edge of the (optionally synchronised) irq. It clears on entry. It is not cleared by i_irq falling.
- FSM states:
  - S_RUN to S_ISR when pending & i_irq_en & !i_stall. On that edge: PC <= ISR_BASE, mepc <= the normal next PC (the branch/jump target if taken, so no redirect is lost), o_irq_ack = 1.
  - S_ISR to S_RUN on i_is_mret & !i_stall: PC <= mepc.
  - MRET in S_RUN is a NOP (PC+4).
  - In S_ISR, new irq edges set pending but are not taken until after return, so there is no nesting.
- Priority: reset, stall, interrupt entry, MRET, jump/branch, sequential.
- o_flush is high on taken, entry or MRET return.
- i_stall: PC, mepc and FSM hold. The pending latch still captures edges. o_irq_ack stays low.
- Reset values: o_pc=RESET_PC, o_mepc=0, state S_RUN, pending=0, o_irq_ack=0, o_in_isr=0. Reset mid-ISR returns to S_RUN and drops pending.

## Timing
- Control decode, o_br_un, o_taken and o_flush are combinational from the current-cycle inputs.
- The new PC is visible one clock after the decision.
- o_irq_ack is asserted combinationally in the entry cycle. o_in_isr rises on the next edge.
- irq latency without synchroniser: pending is set at the first edge sampling i_irq=1 after a 0. Entry is decided the following cycle. o_pc=ISR_BASE one edge later.

## Configuration
- IRQ_SYNC_EN defined: i_irq passes through a two-flop synchroniser before edge detection, adding 2 cycles of latency. The synchroniser flops reset to 0.
- IRQ_SYNC_EN undefined: i_irq is sampled directly by the edge-detect flop.

## Structure
- Shared package:
  - funct3 branch constants (BEQ…BGEU)
  - FSM state typedef (S_RUN, S_ISR)
  - default RESET_PC/ISR_BASE constants
- One sub-module, irq_edge_sync: optional synchroniser plus rising-edge detect, outputting a one-cycle edge pulse.

## Test plan
- Reset released with no activity: o_pc steps 0, 4, 8. o_flush=0.
- BLT with less=1, target 32'h40: o_br_un=1, o_taken=1, next o_pc=32'h40. BGEU with less=1: o_br_un=0, not taken, PC+4.
- JALR with target 32'h103: next o_pc=32'h102, o_flush=1.
- Irq pulse with i_irq_en=1 while a BEQ is taken to 32'h80:
  - o_irq_ack pulses, o_pc becomes 32'h1000, o_mepc=32'h80.
  - MRET returns to 32'h80 and o_in_isr falls.
- Second irq during ISR: not taken until MRET. After return it is entered again. A stall held 3 cycles keeps o_pc constant and the pending edge survives.
- Assert i_rst while in S_ISR: o_pc=RESET_PC, o_in_isr=0, o_mepc=0. With IRQ_SYNC_EN, entry occurs 2 cycles later than without.
